// File: rtl/fpu_share_sched_if.sv
// FPU-side bus of the shared-FPU scheduler.
//   master : scheduler side - drives the operation (req/data/idx), receives
//            the FPU accept and the in-order result stream.
//   slave  : FPU side - the mirror image.
interface fpu_share_sched_if #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32
);
  localparam int IdxW = $clog2(NumIn);

  logic                 fpu_req;
  logic [DataWidth-1:0] fpu_data;
  logic [IdxW-1:0]      fpu_idx;
  logic                 fpu_gnt;
  logic                 fpu_rvalid;
  logic [DataWidth-1:0] fpu_rdata;

  modport master (
    output fpu_req, fpu_data, fpu_idx,
    input  fpu_gnt, fpu_rvalid, fpu_rdata
  );

  modport slave (
    input  fpu_req, fpu_data, fpu_idx,
    output fpu_gnt, fpu_rvalid, fpu_rdata
  );
endinterface

// File: rtl/fpu_share_sched.sv
// Shares one pipelined FPU between NumIn requesters.
// Round-robin arbitration with lock-in while the FPU stalls, an in-order tag
// FIFO routing each returning result to the requester that issued it, and a
// sticky error for results that arrive with nothing outstanding.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   flush_i        : synchronous clear of all scheduler state
//   req_i, data_i  : per-requester operation valid / payload
//   gnt_o          : per-requester accept (one-hot or zero, combinational)
//   fpu_if         : FPU bus (operation out, accept + results in)
//   rvalid_o       : one-hot result strobe to the owning requester
//   rdata_o        : result payload, shared by all requesters
//   outst_o        : operations issued and awaiting a result
//   err_o          : sticky, result received with nothing outstanding
//
// Lock FSM
//   state  | meaning
//   LkFree | winner comes from the round-robin search
//   LkHeld | FPU stalled an offer; lock_idx_q is presented until accepted
module fpu_share_sched #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter int MaxOutst  = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
  output logic [NumIn-1:0]                    gnt_o,
  fpu_share_sched_if.master                   fpu_if,
  output logic [NumIn-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic [$clog2(MaxOutst+1)-1:0]       outst_o,
  output logic                                err_o
);

  localparam int IdxW = $clog2(NumIn);
  localparam int CntW = $clog2(MaxOutst + 1);
  localparam int PtrW = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;

  typedef enum logic {LkFree = 1'b0, LkHeld = 1'b1} lock_state_e;

  lock_state_e     lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] tag_q [MaxOutst];
  logic [IdxW-1:0] tag_d [MaxOutst];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] search_idx;
  logic [IdxW-1:0] pos_idx;
  logic            found;
  int              pos;
  logic [IdxW-1:0] win_idx;
  logic            not_full;
  logic            offer;
  logic            issue;
  logic            pop;

  // Cyclic search for the first active request starting at rr_q.
  always_comb begin
    search_idx = '0;
    pos_idx    = '0;
    found      = 1'b0;
    pos        = 0;
    for (int k = 0; k < NumIn; k++) begin
      pos = int'(rr_q) + k;
      if (pos >= NumIn) pos = pos - NumIn;
      pos_idx = IdxW'(pos);
      if (!found && req_i[pos_idx]) begin
        found      = 1'b1;
        search_idx = pos_idx;
      end
    end
  end

  // Fullness uses the registered count only: a result popping this cycle
  // does not free a slot until the next one.
  assign not_full = (cnt_q < CntW'(MaxOutst));
  assign offer    = (|req_i) & not_full;
  assign issue    = offer & fpu_if.fpu_gnt;
  assign pop      = fpu_if.fpu_rvalid & (cnt_q != '0) & ~flush_i;

  // Lock FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= LkFree;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Lock FSM: next state. A full FIFO suppresses the offer, so an existing
  // lock simply persists until the handshake eventually happens.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d     = LkFree;
      lock_idx_d = '0;
    end else if (issue) begin
      lock_d = LkFree;
    end else if (offer && lock_q == LkFree) begin
      lock_d     = LkHeld;
      lock_idx_d = search_idx;
    end
  end

  // Lock FSM: outputs
  always_comb begin
    win_idx = (lock_q == LkHeld) ? lock_idx_q : search_idx;
  end

  always_comb begin
    fpu_if.fpu_req  = offer;
    fpu_if.fpu_idx  = offer ? win_idx : '0;
    fpu_if.fpu_data = offer ? data_i[win_idx] : '0;
    gnt_o           = '0;
    if (issue) gnt_o[win_idx] = 1'b1;
    rvalid_o        = '0;
    rdata_o         = '0;
    if (pop) begin
      rvalid_o[tag_q[rptr_q]] = 1'b1;
      rdata_o                 = fpu_if.fpu_rdata;
    end
  end

  always_comb begin
    rr_d   = rr_q;
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (flush_i) begin
      rr_d   = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      // A result landing in the flush cycle has no owner left.
      err_d  = fpu_if.fpu_rvalid;
    end else begin
      if (issue) begin
        rr_d          = (win_idx == IdxW'(NumIn - 1)) ? '0 : win_idx + 1'b1;
        tag_d[wptr_q] = win_idx;
        wptr_d        = (wptr_q == PtrW'(MaxOutst - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = (rptr_q == PtrW'(MaxOutst - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({issue, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (fpu_if.fpu_rvalid && cnt_q == '0) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < MaxOutst; i++) tag_q[i] <= '0;
    end else begin
      rr_q   <= rr_d;
      tag_q  <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign outst_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_fpu_share_sched.sv
// Randomized and directed bench for fpu_share_sched against a queue-based
// reference model of the arbitration, lock and result-routing rules.
module tb_fpu_share_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MO = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [N-1:0]         req;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0]         gnt;
  logic [N-1:0]         rvalid;
  logic [DW-1:0]        rdata;
  logic [2:0]           outst;
  logic                 err;

  fpu_share_sched_if #(.NumIn(N), .DataWidth(DW)) fif ();

  fpu_share_sched #(.NumIn(N), .DataWidth(DW), .MaxOutst(MO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .req_i    (req),
    .data_i   (data),
    .gnt_o    (gnt),
    .fpu_if   (fif.master),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .outst_o  (outst),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int m_rr;
  bit m_lk;
  int m_lki;
  int m_q[$];
  bit m_err;

  // last cycle's observed combinational outputs
  logic [N-1:0]  o_gnt, o_rv;
  logic [1:0]    o_idx;
  logic          o_req;
  logic [DW-1:0] o_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lk = 0; m_lki = 0; m_q.delete(); m_err = 0;
  endtask

  // Called at posedge+1 with inputs set; checks the cycle, advances the model.
  task automatic cycle();
    int win;
    bit any, freq, issue, pop, was_empty, found;
    logic [N-1:0] e_gnt, e_rv;
    logic [DW-1:0] e_rd, e_dat;
    #2;
    any   = (req != '0);
    freq  = any && (m_q.size() < MO);
    win   = 0;
    found = 0;
    if (m_lk) win = m_lki;
    else
      for (int k = 0; k < N; k++)
        if (!found && req[(m_rr + k) % N]) begin
          found = 1;
          win = (m_rr + k) % N;
        end
    issue     = freq && fif.fpu_gnt;
    was_empty = (m_q.size() == 0);
    pop       = fif.fpu_rvalid && !was_empty && !flush;
    e_gnt = '0;
    if (issue) e_gnt[win] = 1'b1;
    e_rv = '0;
    e_rd = '0;
    if (pop) begin
      e_rv[m_q[0]] = 1'b1;
      e_rd = fif.fpu_rdata;
    end
    e_dat = freq ? data[win] : '0;
    check("gnt",     gnt,          e_gnt);
    check("fpu_req", fif.fpu_req,  freq);
    check("fpu_idx", fif.fpu_idx,  freq ? win : 0);
    check("fpu_data", fif.fpu_data, e_dat);
    check("rvalid",  rvalid,       e_rv);
    check("rdata",   rdata,        e_rd);
    check("outst",   outst,        m_q.size());
    check("err",     err,          m_err);
    o_gnt = gnt; o_rv = rvalid; o_idx = fif.fpu_idx; o_req = fif.fpu_req; o_rd = rdata;
    if (flush) begin
      m_rr = 0; m_lk = 0; m_q.delete(); m_err = fif.fpu_rvalid;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fif.fpu_rvalid && was_empty) m_err = 1;
      if (issue) begin
        m_q.push_back(win);
        m_rr = (win + 1) % N;
        m_lk = 0;
      end else if (freq && !m_lk) begin
        m_lk = 1;
        m_lki = win;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic g, input logic rv,
                       input logic [DW-1:0] rd, input logic fl);
    req = r;
    fif.fpu_gnt = g;
    fif.fpu_rvalid = rv;
    fif.fpu_rdata = rd;
    flush = fl;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    cycle();
  endtask

  task automatic do_reset();
    req = '0; flush = 0; data = '0;
    fif.fpu_gnt = 0; fif.fpu_rvalid = 0; fif.fpu_rdata = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  logic [N-1:0] seq39 [5];
  logic [N-1:0] rv41 [3];
  logic [DW-1:0] rd41 [3];
  logic [N-1:0] r;
  bit g, rv, fl;

  initial begin
    rst = 1;
    model_reset();
    do_reset();
    check("reset_outst", outst, 0);
    check("reset_err", err, 0);

    // all four requesting, never a result: 0001,0010,0100,1000 then full
    seq39 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1, 0, 0, 0);
      check("rr_seq_gnt", o_gnt, seq39[i]);
    end
    check("full_outst", outst, 4);

    // full + result in the same cycle: no issue, count drops, issue next
    drive(4'b1111, 1, 1, 32'h55, 0);
    check("full_pop_gnt", o_gnt, 4'b0000);
    check("full_pop_rv", o_rv, 4'b0001);
    check("full_pop_outst", outst, 3);
    drive(4'b1111, 1, 0, 0, 0);
    check("after_pop_gnt", o_gnt, 4'b0001);

    // lock-in: winner 1 held while req[0] rises
    do_reset();
    drive(4'b0110, 0, 0, 0, 0); check("lock_idx0", o_idx, 1);
    drive(4'b0110, 0, 0, 0, 0); check("lock_idx1", o_idx, 1);
    drive(4'b0111, 0, 0, 0, 0); check("lock_idx2", o_idx, 1);
    drive(4'b0111, 1, 0, 0, 0); check("lock_idx3", o_idx, 1);
    check("lock_gnt", o_gnt, 4'b0010);
    drive(4'b0110, 0, 0, 0, 0); check("lock_next", o_idx, 2);

    // issue order 2,0,3; results routed back in that order
    do_reset();
    drive(4'b0100, 1, 0, 0, 0);
    drive(4'b0001, 1, 0, 0, 0);
    drive(4'b1000, 1, 0, 0, 0);
    rv41 = '{4'b0100, 4'b0001, 4'b1000};
    rd41 = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 0, 1, rd41[i], 0);
      check("route_rv", o_rv, rv41[i]);
      check("route_rd", o_rd, rd41[i]);
    end
    check("route_outst", outst, 0);

    // stray result sets err; flush clears err, count and pointer
    do_reset();
    drive(4'b0001, 1, 0, 0, 0);
    drive(4'b0000, 0, 1, 32'h7, 0);
    drive(4'b0000, 0, 1, 32'h9, 0);
    check("stray_rv", o_rv, 4'b0000);
    check("stray_err", err, 1);
    drive(4'b0000, 0, 0, 0, 1);
    check("flush_err", err, 0);
    check("flush_outst", outst, 0);
    drive(4'b1111, 0, 0, 0, 0);
    check("flush_rr", o_idx, 0);

    // async reset mid-cycle with two outstanding and a lock held
    do_reset();
    drive(4'b1111, 1, 0, 0, 0);
    drive(4'b1111, 1, 0, 0, 0);
    drive(4'b1111, 0, 0, 0, 0);
    check("pre_rst_outst", outst, 2);
    #2;
    req = '0;
    fif.fpu_gnt = 1;
    rst = 1;
    #1;
    check("arst_outst", outst, 0);
    check("arst_err", err, 0);
    check("arst_gnt", gnt, 0);
    check("arst_rv", rvalid, 0);
    check("arst_rd", rdata, 0);
    check("arst_idx", fif.fpu_idx, 0);
    check("arst_req", fif.fpu_req, 0);
    @(negedge clk);
    fif.fpu_gnt = 0;
    rst = 0;
    @(posedge clk);
    #1;
    model_reset();
    drive(4'b0000, 0, 1, 32'h3, 0);
    check("post_rst_rv", o_rv, 0);
    check("post_rst_err", err, 1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = 4'($urandom_range(0, 15));
      if (m_lk) r[m_lki] = 1'b1;
      g  = ($urandom_range(0, 3) != 0);
      rv = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      fl = ($urandom_range(0, 60) == 0);
      drive(r, g, rv, $urandom, fl);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
